// File: rtl/seg_pkg.sv
// Shared constants for the result display: hex segment patterns (g..a),
// operator glyphs, blank pattern and the digit-index type.
package seg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OP_ADD = 7'h77;
  localparam logic [6:0] SEG_OP_SUB = 7'h6D;
  localparam logic [6:0] SEG_BLANK  = 7'h00;

  localparam digit_idx_t IDX_C  = 2'd0;
  localparam digit_idx_t IDX_B  = 2'd1;
  localparam digit_idx_t IDX_OP = 2'd2;
  localparam digit_idx_t IDX_A  = 2'd3;

endpackage

// File: rtl/hex2seg.sv
// Combinational 4-bit value to active-high 7-segment pattern (seg[0]=a).
module hex2seg
  import seg_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    seg = SEG_HEX[val];
  end

endmodule

// File: rtl/result_seg_display.sv
// Four-digit scanned display of "a op b = c" captured once per frame.
// Optional overflow/borrow decimal point on the result digit: RESULT_OVF_DP_EN.
module result_seg_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mux_sel,
  input  logic [3:0] input_a,
  input  logic [3:0] input_b,
  input  logic [3:0] output_c,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  digit_idx_t       idx_r;
  digit_idx_t       next_idx_s;
  logic             first_r;
  logic             tick_s;
  logic             snap_s;

  logic             f_en_r, f_sel_r;
  logic [3:0]       f_a_r, f_b_r, f_c_r;
  logic             d_en_s, d_sel_s;
  logic [3:0]       d_a_s, d_b_s, d_c_s;

  logic [3:0]       digit_val_s;
  logic [6:0]       hex_seg_s;
  logic             ovf_s;
  logic [3:0]       an_nx_s;
  logic [6:0]       seg_nx_s;
  logic             dp_nx_s;

  assign tick_s     = (cnt_r == CNT_MAX);
  assign next_idx_s = idx_r + 2'd1;
  // The first tick after reset captures too, so the display never shows stale zeros
  assign snap_s     = tick_s && (first_r || (idx_r == IDX_A));

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      idx_r   <= IDX_C;
      first_r <= 1'b1;
    end else if (tick_s) begin
      cnt_r   <= '0;
      idx_r   <= next_idx_s;
      first_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  // Frame snapshot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_en_r  <= 1'b0;
      f_sel_r <= 1'b0;
      f_a_r   <= 4'h0;
      f_b_r   <= 4'h0;
      f_c_r   <= 4'h0;
    end else if (snap_s) begin
      f_en_r  <= en;
      f_sel_r <= mux_sel;
      f_a_r   <= input_a;
      f_b_r   <= input_b;
      f_c_r   <= output_c;
    end
  end

  // On a capturing tick the new digit must already use the values being captured
  assign d_en_s  = snap_s ? en       : f_en_r;
  assign d_sel_s = snap_s ? mux_sel  : f_sel_r;
  assign d_a_s   = snap_s ? input_a  : f_a_r;
  assign d_b_s   = snap_s ? input_b  : f_b_r;
  assign d_c_s   = snap_s ? output_c : f_c_r;

`ifdef RESULT_OVF_DP_EN
  logic [4:0] sum_s;
  assign sum_s = {1'b0, d_a_s} + {1'b0, d_b_s};
  assign ovf_s = d_sel_s ? (d_a_s < d_b_s) : sum_s[4];
`else
  assign ovf_s = 1'b0;
`endif

  // Nibble selection for the single shared decoder
  always_comb begin
    digit_val_s = d_c_s;
    case (next_idx_s)
      IDX_A:   digit_val_s = d_a_s;
      IDX_B:   digit_val_s = d_b_s;
      IDX_C:   digit_val_s = d_c_s;
      default: digit_val_s = d_c_s;
    endcase
  end

  hex2seg u_hex2seg (
    .val (digit_val_s),
    .seg (hex_seg_s)
  );

  // Next output pattern for the digit about to be shown
  always_comb begin
    an_nx_s  = 4'b0000;
    seg_nx_s = SEG_BLANK;
    dp_nx_s  = 1'b0;
    if (d_en_s) begin
      an_nx_s  = 4'b0001 << next_idx_s;
      seg_nx_s = (next_idx_s == IDX_OP) ? (d_sel_s ? SEG_OP_SUB : SEG_OP_ADD)
                                        : hex_seg_s;
      dp_nx_s  = ovf_s && (next_idx_s == IDX_C);
    end else begin
      an_nx_s  = 4'b0000;
      seg_nx_s = SEG_BLANK;
      dp_nx_s  = 1'b0;
    end
  end

  // Registered display outputs, updated only when the digit advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b0000;
      seg <= SEG_BLANK;
      dp  <= 1'b0;
    end else if (tick_s) begin
      an  <= an_nx_s;
      seg <= seg_nx_s;
      dp  <= dp_nx_s;
    end
  end

endmodule
